minaret_mem_arb: RTL and testbench

- Memory-side arbiter directly downstream of the minaret core.
- Accepts the core's instruction-fetch port (read-only) and data port (read/write, mask-qualified) and serialises them onto one shared valid/ready memory bus.
- Arbitration is round-robin on conflict; a per-transaction watchdog terminates hung bus accesses with an error response.

---
 rtl/minaret_mem_arb.sv | 140 ++++++++++++++
 tb/tb_minaret_mem_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minaret_mem_arb.sv
// minaret_mem_arb: serialises the core's fetch and data ports onto one valid/ready memory bus
// Round-robin on conflict, one outstanding transaction, watchdog-terminated bus accesses.
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   imem_valid_i/addr_i             fetch request (held until imem_ready_o)
//   imem_ready_o/rdata_o/err_o      one-cycle fetch response
//   dmem_valid_i/addr_i/wdata_i     data request (held until dmem_ready_o)
//   dmem_rmask_i/wmask_i            byte masks; nonzero wmask means store
//   dmem_ready_o/rdata_o/err_o      one-cycle data response
//   mem_valid_o/instr_o/addr_o      shared bus request
//   mem_wdata_o/wstrb_o             bus store data and strobes (0 = read)
//   mem_ready_i/rdata_i             bus completion and read data
module minaret_mem_arb #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_ready_o,
    output logic [31:0] imem_rdata_o,
    output logic        imem_err_o,
    input  logic        dmem_valid_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_rmask_i,
    input  logic [3:0]  dmem_wmask_i,
    output logic        dmem_ready_o,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_err_o,
    output logic        mem_valid_o,
    output logic        mem_instr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t           state_q;
    logic             last_d_q;
    logic [CNT_W-1:0] cnt_q;
    logic             imem_ready_q, imem_err_q, dmem_ready_q, dmem_err_q;
    logic [31:0]      imem_rdata_q, dmem_rdata_q;
    logic             mem_valid_q, mem_instr_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;
    logic [3:0]       mem_wstrb_q;
    logic             grant_instr, timed_out;
    // reads are always full-word, so the read mask has no effect on the bus
    logic             unused_rmask;
    assign unused_rmask = ^dmem_rmask_i;
    // fetch wins when it is the only requester, or on conflict when data was granted last
    assign grant_instr = imem_valid_i & (~dmem_valid_i | last_d_q);
    assign timed_out   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_d_q     <= 1'b1;
            cnt_q        <= '0;
            imem_ready_q <= 1'b0;
            imem_err_q   <= 1'b0;
            imem_rdata_q <= '0;
            dmem_ready_q <= 1'b0;
            dmem_err_q   <= 1'b0;
            dmem_rdata_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_instr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imem_valid_i | dmem_valid_i) begin
                        mem_valid_q <= 1'b1;
                        mem_instr_q <= grant_instr;
                        mem_addr_q  <= grant_instr ? imem_addr_i : dmem_addr_i;
                        mem_wdata_q <= grant_instr ? '0 : dmem_wdata_i;
                        mem_wstrb_q <= grant_instr ? 4'h0 : dmem_wmask_i;
                        last_d_q    <= ~grant_instr;
                        cnt_q       <= '0;
                        state_q     <= BUS;
                    end
                end
                BUS: begin
                    if (mem_ready_i) begin
                        if (mem_instr_q) begin
                            imem_ready_q <= 1'b1;
                            imem_err_q   <= 1'b0;
                            imem_rdata_q <= mem_rdata_i;
                        end else begin
                            dmem_ready_q <= 1'b1;
                            dmem_err_q   <= 1'b0;
                            dmem_rdata_q <= mem_rdata_i;
                        end
                        mem_valid_q <= 1'b0;
                        mem_wstrb_q <= '0;
                        state_q     <= RESP;
                    end else if (timed_out) begin
                        if (mem_instr_q) begin
                            imem_ready_q <= 1'b1;
                            imem_err_q   <= 1'b1;
                            imem_rdata_q <= '0;
                        end else begin
                            dmem_ready_q <= 1'b1;
                            dmem_err_q   <= 1'b1;
                            dmem_rdata_q <= '0;
                        end
                        mem_valid_q <= 1'b0;
                        mem_wstrb_q <= '0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // one dead cycle lets the core drop the valid it still holds for the finished request
                default: begin
                    imem_ready_q <= 1'b0;
                    imem_err_q   <= 1'b0;
                    dmem_ready_q <= 1'b0;
                    dmem_err_q   <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end
    assign imem_ready_o = imem_ready_q;
    assign imem_rdata_o = imem_rdata_q;
    assign imem_err_o   = imem_err_q;
    assign dmem_ready_o = dmem_ready_q;
    assign dmem_rdata_o = dmem_rdata_q;
    assign dmem_err_o   = dmem_err_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_instr_o  = mem_instr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wstrb_o  = mem_wstrb_q;
endmodule

// File: tb/tb_minaret_mem_arb.sv
// tb_minaret_mem_arb: vector table plus scoreboarded sequences for the memory arbiter
module tb_minaret_mem_arb;
    localparam int TO = 8;
    logic        clk = 1'b0, reset_i = 1'b1;
    logic        imem_valid_i = 1'b0, dmem_valid_i = 1'b0;
    logic [31:0] imem_addr_i = '0, dmem_addr_i = '0, dmem_wdata_i = '0;
    logic [3:0]  dmem_rmask_i = '0, dmem_wmask_i = '0;
    logic        imem_ready_o, imem_err_o, dmem_ready_o, dmem_err_o;
    logic [31:0] imem_rdata_o, dmem_rdata_o;
    logic        mem_valid_o, mem_instr_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    int          checks = 0, errors = 0;
    int          mem_wait = 0, bus_cnt = 0;
    logic [31:0] mem_key = '0;
    logic        man_en = 1'b0, man_ready = 1'b0;
    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        err;
        logic [31:0] rdata;
    } txn_t;
    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wm;
        logic [3:0]  rm;
        int          wt;
        logic [31:0] rd;
    } vec_t;
    txn_t bus_q[$], rsp_q[$];
    minaret_mem_arb #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .imem_valid_i(imem_valid_i), .imem_addr_i(imem_addr_i),
        .imem_ready_o(imem_ready_o), .imem_rdata_o(imem_rdata_o), .imem_err_o(imem_err_o),
        .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .dmem_rmask_i(dmem_rmask_i), .dmem_wmask_i(dmem_wmask_i),
        .dmem_ready_o(dmem_ready_o), .dmem_rdata_o(dmem_rdata_o), .dmem_err_o(dmem_err_o),
        .mem_valid_o(mem_valid_o), .mem_instr_o(mem_instr_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );
    always #5 clk = ~clk;
    // memory model: readies after mem_wait cycles of mem_valid, data is address xor key
    assign mem_ready_i = man_en ? man_ready : (mem_valid_o && bus_cnt == mem_wait);
    assign mem_rdata_i = mem_addr_o ^ mem_key;
    always @(posedge clk) bus_cnt <= mem_valid_o ? bus_cnt + 1 : 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic void push(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic err);
        txn_t t;
        t.instr = instr;
        t.addr  = addr;
        t.wdata = wdata;
        t.wstrb = wstrb;
        t.err   = err;
        t.rdata = err ? 32'h0 : addr ^ mem_key;
        bus_q.push_back(t);
        rsp_q.push_back(t);
    endfunction
    // bus monitor: each new request is popped and compared, then must stay stable
    logic        mv_prev = 1'b0;
    logic [68:0] bus_hold;
    always @(negedge clk) begin
        txn_t b;
        if (mem_valid_o && !mv_prev) begin
            bus_hold = {mem_instr_o, mem_addr_o, mem_wdata_o, mem_wstrb_o};
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_extra: got grant addr %0h expected none", mem_addr_o);
            end else begin
                b = bus_q.pop_front();
                chk("bus_req", {mem_instr_o, mem_addr_o, mem_wstrb_o, mem_wstrb_o != 0 ? mem_wdata_o : 32'h0},
                    {b.instr, b.addr, b.wstrb, b.wstrb != 0 ? b.wdata : 32'h0});
            end
        end else if (mem_valid_o) begin
            chk("bus_stable", {mem_instr_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, bus_hold);
        end
        mv_prev = mem_valid_o;
    end
    // response monitor: every ready pulse must match the head of the scoreboard
    always @(negedge clk) begin
        txn_t r;
        if (imem_ready_o || dmem_ready_o) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_extra: got ready i=%0b d=%0b expected none", imem_ready_o, dmem_ready_o);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp", {imem_ready_o, dmem_ready_o, r.instr ? imem_err_o : dmem_err_o,
                            r.instr ? imem_rdata_o : dmem_rdata_o},
                    {r.instr, !r.instr, r.err, r.rdata});
            end
        end
    end
    task automatic drive_i(input logic [31:0] addr, input int n, input int lat);
        int t;
        for (int k = 0; k < n; k++) begin
            imem_valid_i = 1'b1;
            imem_addr_i  = addr + 32'(4 * k);
            t = 0;
            @(negedge clk);
            while (!imem_ready_o && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) begin
                checks++;
                errors++;
                $display("FAIL i_hang: got no imem_ready expected one within 200 cycles");
            end else if (lat >= 0) chk("i_lat", t, lat);
            @(posedge clk);
            #1;
        end
        imem_valid_i = 1'b0;
    endtask
    task automatic drive_d(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wm,
                           input logic [3:0] rm, input int n, input int lat);
        int t;
        for (int k = 0; k < n; k++) begin
            dmem_valid_i = 1'b1;
            dmem_addr_i  = addr + 32'(4 * k);
            dmem_wdata_i = wdata + 32'(k);
            dmem_wmask_i = wm;
            dmem_rmask_i = rm;
            t = 0;
            @(negedge clk);
            while (!dmem_ready_o && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) begin
                checks++;
                errors++;
                $display("FAIL d_hang: got no dmem_ready expected one within 200 cycles");
            end else if (lat >= 0) chk("d_lat", t, lat);
            @(posedge clk);
            #1;
        end
        dmem_valid_i = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected one");
        $fatal(1, "global timeout");
    end
    initial begin
        vec_t        vt[8];
        vec_t        v;
        logic        err;
        int          lat;
        vt[0] = '{1'b1, 32'h10,  32'h0,        4'h0, 4'h0, 1,  32'hDEADBEEF};
        vt[1] = '{1'b0, 32'h100, 32'h12345678, 4'hF, 4'h0, 0,  32'h0BADF00D};
        vt[2] = '{1'b0, 32'h200, 32'h0,        4'h0, 4'hF, 3,  32'hA5A55A5A};
        vt[3] = '{1'b0, 32'h204, 32'h0,        4'h0, 4'h2, 2,  32'h00C0FFEE};
        vt[4] = '{1'b0, 32'h300, 32'h87654321, 4'h3, 4'hC, 1,  32'h13579BDF};
        vt[5] = '{1'b1, 32'h400, 32'h0,        4'h0, 4'h0, 7,  32'h2468ACE0};
        vt[6] = '{1'b0, 32'h500, 32'h0,        4'h0, 4'hF, 8,  32'hFFFF0000};
        vt[7] = '{1'b1, 32'h600, 32'h0,        4'h0, 4'h0, 20, 32'h11112222};
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("reset_rsp", {imem_ready_o, imem_rdata_o, imem_err_o, dmem_ready_o, dmem_rdata_o, dmem_err_o}, '0);
        chk("reset_bus", {mem_valid_o, mem_instr_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, '0);
        @(posedge clk);
        #1;
        // conflict from reset: fetch first, then data
        mem_wait = 1;
        mem_key  = 32'h1111_0000;
        push(1'b1, 32'h1000, 32'h0, 4'h0, 1'b0);
        push(1'b0, 32'h2000, 32'h0, 4'h0, 1'b0);
        fork
            drive_i(32'h1000, 1, -1);
            drive_d(32'h2000, 32'h0, 4'h0, 4'hF, 1, -1);
        join
        // both held valid: I, D, I, D
        push(1'b1, 32'h3000, 32'h0, 4'h0, 1'b0);
        push(1'b0, 32'h4000, 32'hCAFE0000, 4'hF, 1'b0);
        push(1'b1, 32'h3004, 32'h0, 4'h0, 1'b0);
        push(1'b0, 32'h4004, 32'hCAFE0001, 4'hF, 1'b0);
        fork
            drive_i(32'h3000, 2, -1);
            drive_d(32'h4000, 32'hCAFE0000, 4'hF, 4'h0, 2, -1);
        join
        // back-to-back zero-wait fetches
        mem_wait = 0;
        for (int k = 0; k < 3; k++) push(1'b1, 32'h5000 + 32'(4 * k), 32'h0, 4'h0, 1'b0);
        drive_i(32'h5000, 3, 2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            v        = vt[i];
            mem_wait = v.wt;
            mem_key  = v.addr ^ v.rd;
            err      = v.wt >= TO;
            lat      = err ? TO + 1 : v.wt + 2;
            push(v.instr, v.addr, v.wdata, v.instr ? 4'h0 : v.wm, err);
            if (v.instr) drive_i(v.addr, 1, lat);
            else drive_d(v.addr, v.wdata, v.wm, v.rm, 1, lat);
            @(negedge clk);
            chk("rdata_hold", v.instr ? imem_rdata_o : dmem_rdata_o, err ? 32'h0 : v.rd);
            @(posedge clk);
            #1;
        end
        // reset while the bus is waiting abandons the access
        mem_wait = 1000;
        mem_key  = 32'h0;
        dmem_valid_i = 1'b1;
        dmem_addr_i  = 32'h6000;
        dmem_wmask_i = 4'h0;
        dmem_rmask_i = 4'hF;
        bus_q.push_back('{1'b0, 32'h6000, 32'h0, 4'h0, 1'b0, 32'h0});
        repeat (4) @(posedge clk);
        #1 reset_i = 1'b1;
        dmem_valid_i = 1'b0;
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("reset_abandon", {mem_valid_o, imem_ready_o, dmem_ready_o}, 3'b000);
        man_en    = 1'b1;
        man_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("late_ready", {mem_valid_o, imem_ready_o, dmem_ready_o}, 3'b000);
        end
        @(posedge clk);
        #1 man_en = 1'b0;
        man_ready = 1'b0;
        mem_wait  = 0;
        mem_key   = 32'h7777_0000;
        push(1'b1, 32'h7000, 32'h0, 4'h0, 1'b0);
        drive_i(32'h7000, 1, 2);
        repeat (3) @(posedge clk);
        chk("bus_q_empty", bus_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
